// File: rtl/idex_hazard_stage.sv
`default_nettype none
// =============================================================================
// idex_hazard_stage : ID/EX pipeline register with load-use bubble insertion.
// Optional feature macro: IDEX_STALL_CNT_EN (saturating bubble counter).
// Revision: 1.0
// =============================================================================
module idex_hazard_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 3,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_ID,
  input  logic [REG_ID_W-1:0] Rx_a_ID,
  input  logic [REG_ID_W-1:0] Ry_a_ID,
  input  logic [REG_ID_W-1:0] Rz_a_ID,
  input  logic                usesRx_ID,
  input  logic                usesRy_ID,
  input  logic [REG_ID_W-1:0] registerToWriteId_a_ID,
  input  logic                regWrite_a_ID,
  input  logic                memRead_a_ID,
  input  logic                memWrite_a_ID,
  input  logic                readSpecReg_a_ID,
  input  logic                writeSpecReg_a_ID,
  input  logic [DATA_W-1:0]   rxData_ID,
  input  logic [DATA_W-1:0]   ryData_ID,
  input  logic [DATA_W-1:0]   imm_ID,
  input  logic [ALUOP_W-1:0]  aluOp_ID,
  input  logic                stallExt,
  input  logic                flushIDEX,
  output logic                valid_IDEX,
  output logic [REG_ID_W-1:0] Rx_a_IDEX,
  output logic [REG_ID_W-1:0] Ry_a_IDEX,
  output logic [REG_ID_W-1:0] Rz_a_IDEX,
  output logic                usesRx_IDEX,
  output logic                usesRy_IDEX,
  output logic [REG_ID_W-1:0] registerToWriteId_a_IDEX,
  output logic                regWrite_a_IDEX,
  output logic                memRead_a_IDEX,
  output logic                memWrite_a_IDEX,
  output logic                readSpecReg_a_IDEX,
  output logic                writeSpecReg_a_IDEX,
  output logic [DATA_W-1:0]   rxData_IDEX,
  output logic [DATA_W-1:0]   ryData_IDEX,
  output logic [DATA_W-1:0]   imm_IDEX,
  output logic [ALUOP_W-1:0]  aluOp_IDEX,
  output logic                pcWrite,
  output logic                ifidWrite,
  output logic [15:0]         stallCount
);

  localparam int c_field_w = 1 + 4*REG_ID_W + 7 + 3*DATA_W + ALUOP_W;

  logic [c_field_w-1:0] w_id_fields;
  logic [c_field_w-1:0] r_idex;
  logic                 w_rx_hit;
  logic                 w_ry_hit;
  logic                 w_load_use;
  logic                 w_bubble_load;

  // An invalid ID slot enters the register as an all-zero bubble.
  assign w_id_fields = valid_ID ?
      {valid_ID, Rx_a_ID, Ry_a_ID, Rz_a_ID, registerToWriteId_a_ID,
       usesRx_ID, usesRy_ID, regWrite_a_ID, memRead_a_ID, memWrite_a_ID,
       readSpecReg_a_ID, writeSpecReg_a_ID, rxData_ID, ryData_ID, imm_ID, aluOp_ID}
      : '0;

  assign {valid_IDEX, Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX,
          usesRx_IDEX, usesRy_IDEX, regWrite_a_IDEX, memRead_a_IDEX, memWrite_a_IDEX,
          readSpecReg_a_IDEX, writeSpecReg_a_IDEX, rxData_IDEX, ryData_IDEX,
          imm_IDEX, aluOp_IDEX} = r_idex;

  assign w_rx_hit   = usesRx_ID && (registerToWriteId_a_IDEX == Rx_a_ID);
  assign w_ry_hit   = usesRy_ID && (registerToWriteId_a_IDEX == Ry_a_ID);
  assign w_load_use = valid_IDEX && memRead_a_IDEX && regWrite_a_IDEX && valid_ID &&
                      (w_rx_hit || w_ry_hit);

  assign pcWrite   = ~(w_load_use | stallExt);
  assign ifidWrite = ~(w_load_use | stallExt);

  // A load-use bubble only lands when neither flush nor external stall takes precedence.
  assign w_bubble_load = !flushIDEX && !stallExt && w_load_use;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (flushIDEX) begin
      r_idex <= '0;
    end else if (stallExt) begin
      r_idex <= r_idex;
    end else if (w_load_use) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_id_fields;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= 16'h0000;
    end else if (w_bubble_load && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end
  end

  assign stallCount = r_stall_count;
`else
  logic w_unused_bubble;
  assign w_unused_bubble = w_bubble_load;
  assign stallCount      = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idex_hazard_stage.sv
`default_nettype none
// =============================================================================
// tb_idex_hazard_stage : directed + randomized self-checking bench.
// Revision: 1.0
// =============================================================================
module tb_idex_hazard_stage;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rx, ry, rz, rd;
    logic        urx, ury, rw, mr, mw, rs, ws;
    logic [15:0] rxd, ryd, imm;
    logic [3:0]  op;
  } ins_t;

`ifdef IDEX_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stallExt, flushIDEX;
  ins_t id;

  logic        valid_IDEX;
  logic [2:0]  Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX;
  logic        usesRx_IDEX, usesRy_IDEX, regWrite_a_IDEX, memRead_a_IDEX;
  logic        memWrite_a_IDEX, readSpecReg_a_IDEX, writeSpecReg_a_IDEX;
  logic [15:0] rxData_IDEX, ryData_IDEX, imm_IDEX;
  logic [3:0]  aluOp_IDEX;
  logic        pcWrite, ifidWrite;
  logic [15:0] stallCount;

  idex_hazard_stage dut (
    .clk(clk), .rst(rst), .valid_ID(id.valid),
    .Rx_a_ID(id.rx), .Ry_a_ID(id.ry), .Rz_a_ID(id.rz),
    .usesRx_ID(id.urx), .usesRy_ID(id.ury),
    .registerToWriteId_a_ID(id.rd), .regWrite_a_ID(id.rw),
    .memRead_a_ID(id.mr), .memWrite_a_ID(id.mw),
    .readSpecReg_a_ID(id.rs), .writeSpecReg_a_ID(id.ws),
    .rxData_ID(id.rxd), .ryData_ID(id.ryd), .imm_ID(id.imm), .aluOp_ID(id.op),
    .stallExt(stallExt), .flushIDEX(flushIDEX),
    .valid_IDEX(valid_IDEX), .Rx_a_IDEX(Rx_a_IDEX), .Ry_a_IDEX(Ry_a_IDEX),
    .Rz_a_IDEX(Rz_a_IDEX), .usesRx_IDEX(usesRx_IDEX), .usesRy_IDEX(usesRy_IDEX),
    .registerToWriteId_a_IDEX(registerToWriteId_a_IDEX),
    .regWrite_a_IDEX(regWrite_a_IDEX), .memRead_a_IDEX(memRead_a_IDEX),
    .memWrite_a_IDEX(memWrite_a_IDEX), .readSpecReg_a_IDEX(readSpecReg_a_IDEX),
    .writeSpecReg_a_IDEX(writeSpecReg_a_IDEX), .rxData_IDEX(rxData_IDEX),
    .ryData_IDEX(ryData_IDEX), .imm_IDEX(imm_IDEX), .aluOp_IDEX(aluOp_IDEX),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .stallCount(stallCount)
  );

  ins_t dut_q;
  assign dut_q = {valid_IDEX, Rx_a_IDEX, Ry_a_IDEX, Rz_a_IDEX, registerToWriteId_a_IDEX,
                  usesRx_IDEX, usesRy_IDEX, regWrite_a_IDEX, memRead_a_IDEX,
                  memWrite_a_IDEX, readSpecReg_a_IDEX, writeSpecReg_a_IDEX,
                  rxData_IDEX, ryData_IDEX, imm_IDEX, aluOp_IDEX};

  // Reference state: the instruction occupying ID/EX and the number of bubbles paid.
  ins_t        m;
  logic [15:0] m_cnt;
  bit          m_known = 1'b0;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic ins_t mk_lw(input logic [2:0] dst, input logic [2:0] base);
    ins_t r = '0;
    r.valid = 1'b1; r.rx = base; r.urx = 1'b1; r.ry = dst; r.rd = dst;
    r.rw = 1'b1; r.mr = 1'b1; r.rxd = 16'h1000; r.imm = 16'h0004; r.op = 4'h0;
    return r;
  endfunction

  function automatic ins_t mk_addu(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    ins_t r = '0;
    r.valid = 1'b1; r.rx = a; r.ry = b; r.rz = d; r.rd = d;
    r.urx = 1'b1; r.ury = 1'b1; r.rw = 1'b1;
    r.rxd = 16'h1111 * 16'(a); r.ryd = 16'h0101 * 16'(b); r.op = 4'h1;
    return r;
  endfunction

  function automatic ins_t mk_addiu(input logic [2:0] a, input logic [15:0] k);
    ins_t r = '0;
    r.valid = 1'b1; r.rx = a; r.rd = a; r.urx = 1'b1; r.rw = 1'b1;
    r.rxd = 16'h00A5; r.imm = k; r.op = 4'h2;
    return r;
  endfunction

  function automatic ins_t mk_spec_read();
    ins_t r = '0;
    r.valid = 1'b1; r.rs = 1'b1; r.rx = 3'd2; r.rd = 3'd3; r.rw = 1'b1;
    r.rxd = 16'hBEEF; r.op = 4'h3;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    logic [95:0] b;
    ins_t r;
    b = {$urandom, $urandom, $urandom};
    r = b[71:0];
    r.rx = 3'($urandom_range(0, 3));
    r.ry = 3'($urandom_range(0, 3));
    r.rd = 3'($urandom_range(0, 3));
    r.valid = ($urandom_range(0, 7) != 0);
    return r;
  endfunction

  // One clock: check the stall outputs mid-cycle, predict the register, check after the edge.
  task automatic cycle();
    logic        hz;
    ins_t        nxt;
    logic [15:0] ncnt;
    #4;
    hz = m.valid && m.mr && m.rw && id.valid &&
         ((id.urx && (m.rd == id.rx)) || (id.ury && (m.rd == id.ry)));
    if (m_known) begin
      chk("pcWrite", 72'(pcWrite), 72'(!(hz || stallExt)));
      chk("ifidWrite", 72'(ifidWrite), 72'(!(hz || stallExt)));
    end
    ncnt = m_cnt;
    if (!rst) begin
      nxt = '0; ncnt = 16'h0000;
    end else if (flushIDEX) nxt = '0;
    else if (stallExt) nxt = m;
    else if (hz) begin
      nxt = '0;
      if (CNT_EN && ncnt != 16'hFFFF) ncnt = ncnt + 16'h0001;
    end else nxt = id.valid ? id : '0;
    @(posedge clk);
    #1;
    if (!rst) m_known = 1'b1;
    m = nxt; m_cnt = ncnt;
    if (m_known) begin
      chk("idex_contents", 72'(dut_q), 72'(m));
      chk("stallCount", 72'(stallCount), 72'(m_cnt));
    end
  endtask

  initial begin
    m = '0; m_cnt = 16'h0000;
    stallExt = 1'b0; flushIDEX = 1'b0;

    // Reset with random ID contents
    rst = 1'b0;
    id = rand_ins(); cycle();
    id = rand_ins(); cycle();
    chk("t1_valid_IDEX", 72'(valid_IDEX), 72'(0));
    chk("t1_idex_zero", 72'(dut_q), 72'(0));
    chk("t1_pcWrite", 72'(pcWrite), 72'(1));
    chk("t1_ifidWrite", 72'(ifidWrite), 72'(1));
    rst = 1'b1;

    // Load-use: LW R2 then ADDU R2,R3,R4
    id = mk_lw(3'd2, 3'd0); cycle();
    id = mk_addu(3'd2, 3'd3, 3'd4);
    #4;
    chk("t2_pcWrite_stall", 72'(pcWrite), 72'(0));
    chk("t2_ifidWrite_stall", 72'(ifidWrite), 72'(0));
    #(-4 + 4);
    cycle();
    chk("t2_bubble_valid", 72'(valid_IDEX), 72'(0));
    cycle();
    chk("t2_addu_latched", 72'(dut_q), 72'(mk_addu(3'd2, 3'd3, 3'd4)));
    chk("t2_stallCount", 72'(stallCount), 72'(CNT_EN ? 16'd1 : 16'd0));

    // No dependency: LW R2 then ADDU R5,R6,R7
    id = mk_lw(3'd2, 3'd0); cycle();
    id = mk_addu(3'd5, 3'd6, 3'd7); cycle();
    chk("t3_addu_next", 72'(dut_q), 72'(mk_addu(3'd5, 3'd6, 3'd7)));

    // Special-register read after a load never stalls
    id = mk_lw(3'd2, 3'd1); cycle();
    id = mk_spec_read(); cycle();
    chk("t3_spec_latched", 72'(dut_q), 72'(mk_spec_read()));

    // External stall holds ADDIU R1 for three edges
    id = mk_addiu(3'd1, 16'h0007); cycle();
    id = mk_addu(3'd1, 3'd2, 3'd3);
    stallExt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_held", 72'(dut_q), 72'(mk_addiu(3'd1, 16'h0007)));
    end
    stallExt = 1'b0;
    cycle();
    chk("t4_next_loaded", 72'(dut_q), 72'(mk_addu(3'd1, 3'd2, 3'd3)));

    // Flush wins over external stall
    flushIDEX = 1'b1; stallExt = 1'b1;
    cycle();
    chk("t5_valid", 72'(valid_IDEX), 72'(0));
    chk("t5_regWrite", 72'(regWrite_a_IDEX), 72'(0));
    flushIDEX = 1'b0; stallExt = 1'b0;

    // Load-use held off by stallExt: the bubble waits until the stall drops
    id = mk_lw(3'd4, 3'd0); cycle();
    id = mk_addu(3'd0, 3'd4, 3'd5);
    stallExt = 1'b1;
    cycle(); cycle();
    stallExt = 1'b0;
    cycle();
    chk("t5b_bubble", 72'(valid_IDEX), 72'(0));
    cycle();
    chk("t5b_dependent", 72'(dut_q), 72'(mk_addu(3'd0, 3'd4, 3'd5)));

    // Reset in the middle of a load-use stall
    id = mk_lw(3'd2, 3'd0); cycle();
    id = mk_addu(3'd2, 3'd3, 3'd4);
    rst = 1'b0;
    cycle();
    chk("t6_cleared", 72'(dut_q), 72'(0));
    chk("t6_count_zero", 72'(stallCount), 72'(0));
    rst = 1'b1;

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      id        = rand_ins();
      rst       = ($urandom_range(0, 39) != 0);
      stallExt  = ($urandom_range(0, 4) == 0);
      flushIDEX = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
